// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter and fill sequencer for the single write port of a
// 2**AW x DW RAM. One registered write per cycle; a fill sweep preempts arbitration.

module ram_write_arbiter_lane #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          gnt,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] addr_m,
  output logic [DW-1:0] data_m
);
  // Lanes contribute only while granted so the top can OR-reduce them.
  assign addr_m = gnt ? addr : '0;
  assign data_m = gnt ? data : '0;
endmodule

module ram_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 16,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_start,
  input  logic [DW-1:0]        init_data,
  output logic                 init_busy,
  output logic                 init_done,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_wa,
  output logic [DW-1:0]        ram_di
);

  typedef enum logic [0:0] {IDLE, INIT} state_t;

  state_t                    state;
  logic [IW-1:0]             rr_ptr;
  logic [AW-1:0]             fill_cnt;
  logic [DW-1:0]             fill_val;

  logic [NREQ-1:0]           gnt_oh;
  logic [IW-1:0]             gnt_idx;
  logic                      gnt_any;
  logic [IW:0]               scan;
  logic                      arb_en;
  logic [NREQ-1:0][AW-1:0]   lane_addr;
  logic [NREQ-1:0][DW-1:0]   lane_data;
  logic [AW-1:0]             sel_addr;
  logic [DW-1:0]             sel_data;
  logic [IW-1:0]             ptr_nxt;

  assign arb_en = rst_n && (state == IDLE) && !init_start;

  // Rotating search: first valid requester at or after rr_ptr, wrapping mod NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!gnt_any && req_valid[scan[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (arb_en && gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt_oh;
  assign ptr_nxt   = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    ram_write_arbiter_lane #(.AW(AW), .DW(DW)) u_lane (
      .gnt    (gnt_oh[gi]),
      .addr   (req_addr[gi*AW +: AW]),
      .data   (req_data[gi*DW +: DW]),
      .addr_m (lane_addr[gi]),
      .data_m (lane_data[gi])
    );
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | lane_addr[i];
      sel_data = sel_data | lane_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      fill_cnt  <= '0;
      fill_val  <= '0;
      ram_we    <= 1'b0;
      ram_wa    <= '0;
      ram_di    <= '0;
      grant_id  <= '0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          init_done <= 1'b0;
          if (init_start) begin
            ram_we    <= 1'b0;
            fill_val  <= init_data;
            fill_cnt  <= '0;
            init_busy <= 1'b1;
            state     <= INIT;
          end else if (gnt_any) begin
            ram_we    <= 1'b1;
            ram_wa    <= sel_addr;
            ram_di    <= sel_data;
            grant_id  <= gnt_idx;
            rr_ptr    <= ptr_nxt;
          end else begin
            ram_we    <= 1'b0;
          end
        end
        INIT: begin
          ram_we   <= 1'b1;
          ram_wa   <= fill_cnt;
          ram_di   <= fill_val;
          fill_cnt <= fill_cnt + AW'(1);
          // Last address issued: done pulse lines up with the final write.
          if (fill_cnt == '1) begin
            state     <= IDLE;
            init_busy <= 1'b0;
            init_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Randomized and directed bench for ram_write_arbiter with a RAM array and
// a transaction-level reference model.
module tb_ram_write_arbiter;
  localparam int NREQ = 4, AW = 6, DW = 16, DEPTH = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                init_start = 1'b0;
  logic [DW-1:0]       init_data = '0;
  logic                init_busy, init_done;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic [1:0]          grant_id;
  logic                ram_we;
  logic [AW-1:0]       ram_wa;
  logic [DW-1:0]       ram_di;

  ram_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_data(init_data),
    .init_busy(init_busy), .init_done(init_done), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_we) ram[ram_wa] <= ram_di;

  int n_chk = 0, n_pass = 0;

  // Reference model: pointer, sweep progress, predicted outputs, RAM contents.
  int            m_ptr, m_cnt;
  bit            m_init, m_req;
  logic [DW-1:0] m_fill, m_di;
  logic          m_we, m_busy, m_done;
  logic [AW-1:0] m_wa;
  logic [1:0]    m_gid;
  logic [DW-1:0] mem_ref [DEPTH];

  function automatic int pick();
    if (m_init || init_start || !rst_n) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int p;
    p = pick();
    if (p < 0) return '0;
    return NREQ'(1) << p;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_init = 0; m_req = 0; m_fill = '0;
    m_we = 0; m_wa = '0; m_di = '0; m_gid = '0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_step();
    int p;
    if (m_we) mem_ref[m_wa] = m_di;
    p = pick();
    m_req = 0;
    if (m_init) begin
      m_we = 1; m_wa = AW'(m_cnt); m_di = m_fill; m_cnt++;
      m_done = (m_cnt == DEPTH);
      if (m_cnt == DEPTH) begin m_init = 0; m_busy = 0; m_cnt = 0; end
    end else begin
      m_done = 0;
      if (init_start) begin
        m_init = 1; m_busy = 1; m_fill = init_data; m_cnt = 0; m_we = 0;
      end else if (p >= 0) begin
        m_we = 1; m_req = 1; m_wa = req_addr[p*AW +: AW]; m_di = req_data[p*DW +: DW];
        m_gid = 2'(p); m_ptr = (p + 1) % NREQ;
      end else m_we = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; init_start = 0;
    @(negedge clk); rst_n = 0; model_reset();
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = '1; model_reset();
    #3;
    n_chk++; if (req_ready !== '0) $display("FAIL reset_ready got %b exp 0000", req_ready); else n_pass++;
    n_chk++; if ({ram_we, init_busy, init_done} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {ram_we, init_busy, init_done}); else n_pass++;
    n_chk++; if ({ram_wa, ram_di, grant_id} !== '0)
      $display("FAIL reset_regs got %h/%h/%h exp 0/0/0", ram_wa, ram_di, grant_id); else n_pass++;
    req_valid = '0;
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 6'd5, 16'hBEEF);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0100) $display("FAIL single_ready got %b exp 0100", req_ready); else n_pass++;
    tick(); req_valid = '0;
    n_chk++; if ({ram_we, ram_wa, ram_di, grant_id} !== {1'b1, 6'd5, 16'hBEEF, 2'd2})
      $display("FAIL single_write got we=%b wa=%0d di=%h id=%0d exp we=1 wa=5 di=beef id=2",
               ram_we, ram_wa, ram_di, grant_id); else n_pass++;
    tick();
    n_chk++; if (ram[5] !== 16'hBEEF) $display("FAIL single_readback got %h exp beef", ram[5]); else n_pass++;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL single_idle_we got %b exp 0", ram_we); else n_pass++;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), DW'(16'hA000 + i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++; if (req_ready !== NREQ'(1 << (c % 4)))
        $display("FAIL fair_ready[%0d] got %b exp %b", c, req_ready, NREQ'(1 << (c % 4))); else n_pass++;
      tick();
      n_chk++; if (!(ram_we === 1'b1 && grant_id === 2'(c % 4) && ram_di === DW'(16'hA000 + c % 4)))
        $display("FAIL fair_grant[%0d] got we=%b id=%0d di=%h exp we=1 id=%0d", c, ram_we, grant_id, ram_di, c % 4);
      else n_pass++;
    end
    req_valid = '0;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    set_req(3, 6'd33, 16'h0333);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b1000) $display("FAIL wrap_first got %b exp 1000", req_ready); else n_pass++;
    tick();
    set_req(1, 6'd11, 16'h0111);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0010) $display("FAIL wrap_second got %b exp 0010", req_ready); else n_pass++;
    tick();
    n_chk++; if (grant_id !== 2'd1 || ram_wa !== 6'd11) $display("FAIL wrap_second_id got %0d exp 1", grant_id); else n_pass++;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b1000) $display("FAIL wrap_third got %b exp 1000", req_ready); else n_pass++;
    tick(); req_valid = '0;
    n_chk++; if (grant_id !== 2'd3 || ram_di !== 16'h0333) $display("FAIL wrap_third_id got %0d exp 3", grant_id); else n_pass++;
  endtask

  task automatic test_init_sweep();
    int zr, bad;
    do_reset();
    set_req(0, 6'd7, 16'h1234);
    init_start = 1; init_data = 16'h00A5; zr = 0;
    @(negedge clk); if (req_ready === '0) zr++;
    tick(); init_start = 0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); if (req_ready === '0) zr++;
      tick();
      n_chk++;
      if (!(ram_we === 1'b1 && ram_wa === 6'(k) && ram_di === 16'h00A5 &&
            init_busy === (k != DEPTH-1) && init_done === (k == DEPTH-1)))
        $display("FAIL sweep[%0d] got we=%b wa=%0d di=%h busy=%b done=%b", k, ram_we, ram_wa, ram_di, init_busy, init_done);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (zr != 65) $display("FAIL sweep_ready_zero_cycles got %0d exp 65", zr); else n_pass++;
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL sweep_resume_ready got %b exp 0001", req_ready); else n_pass++;
    tick(); req_valid = '0;
    n_chk++; if ({ram_we, ram_wa, ram_di, grant_id} !== {1'b1, 6'd7, 16'h1234, 2'd0})
      $display("FAIL sweep_resume_write got wa=%0d di=%h id=%0d exp 7/1234/0", ram_wa, ram_di, grant_id); else n_pass++;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== 16'h00A5) bad++;
    n_chk++; if (bad != 0) $display("FAIL sweep_fill_content got %0d bad words exp 0", bad); else n_pass++;
    tick();
    n_chk++; if (ram[7] !== 16'h1234) $display("FAIL sweep_post_write got %h exp 1234", ram[7]); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_reset();
    init_start = 1; init_data = 16'hC0DE;
    tick(); init_start = 0;
    n = 0;
    while (ram_wa !== 6'd20 && n < 100) begin tick(); n++; end
    n_chk++; if (n >= 100) $display("FAIL midrst_reach20 got timeout exp wa=20"); else n_pass++;
    #2 rst_n = 0; model_reset();
    #1;
    n_chk++; if ({ram_we, init_busy, init_done} !== 3'b000)
      $display("FAIL midrst_async got %b exp 000", {ram_we, init_busy, init_done}); else n_pass++;
    @(negedge clk); rst_n = 1;
    tick();
    init_start = 1; init_data = 16'h5A5A;
    tick(); init_start = 0;
    tick();
    n_chk++; if ({ram_we, ram_wa, init_busy} !== {1'b1, 6'd0, 1'b1})
      $display("FAIL midrst_restart got we=%b wa=%0d busy=%b exp 1/0/1", ram_we, ram_wa, init_busy); else n_pass++;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin tick(); n++; end
    n_chk++; if (n >= 100 || ram_wa !== 6'd63) $display("FAIL midrst_finish got wa=%0d n=%0d exp wa=63", ram_wa, n); else n_pass++;
  endtask

  task automatic test_init_retrigger();
    int dn;
    bit ok;
    do_reset();
    init_start = 1; init_data = 16'h3C3C;
    tick(); init_start = 0;
    dn = 0; ok = 1;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      if (ram_we !== 1'b1 || ram_wa !== 6'(k)) ok = 0;
      if (init_done === 1'b1) dn++;
      init_start = (k == 30);
    end
    init_start = 0;
    n_chk++; if (!ok) $display("FAIL retrig_sequence got broken exp 0..63"); else n_pass++;
    n_chk++; if (init_done !== 1'b1) $display("FAIL retrig_done_at_63 got %b exp 1", init_done); else n_pass++;
    for (int k = 0; k < 3; k++) begin tick(); if (init_done === 1'b1) dn++; end
    n_chk++; if (dn != 1) $display("FAIL retrig_done_count got %0d exp 1", dn); else n_pass++;
    n_chk++; if ({ram_we, init_busy} !== 2'b00) $display("FAIL retrig_idle got %b exp 00", {ram_we, init_busy}); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid  = NREQ'($urandom);
      req_addr   = (NREQ*AW)'($urandom);
      req_data   = {$urandom, $urandom};
      init_start = ($urandom_range(0, 39) == 0);
      init_data  = DW'($urandom);
      @(negedge clk);
      n_chk++; if (req_ready !== exp_ready())
        $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, exp_ready()); else n_pass++;
      tick();
      n_chk++;
      if (ram_we !== m_we || init_busy !== m_busy || init_done !== m_done ||
          (m_we && (ram_wa !== m_wa || ram_di !== m_di)) || (m_req && grant_id !== m_gid))
        $display("FAIL rand_regs[%0d] got we=%b wa=%0d di=%h id=%0d busy=%b done=%b exp we=%b wa=%0d di=%h id=%0d busy=%b done=%b",
                 c, ram_we, ram_wa, ram_di, grant_id, init_busy, init_done, m_we, m_wa, m_di, m_gid, m_busy, m_done);
      else n_pass++;
    end
    req_valid = '0; init_start = 0;
    tick(); tick();
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== mem_ref[a]) bad++;
    n_chk++; if (bad != 0) $display("FAIL rand_ram_content got %0d bad words exp 0", bad); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_init_sweep();
    test_reset_mid_sweep();
    test_init_retrigger();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_write_arbiter.md
Name: ram_write_arbiter

Overview:
- Round-robin arbiter and init sequencer for the single write port of the 64x16 multi-port RAM (one synchronous write port, two asynchronous read ports).
- Shares the write port between NREQ requesters using a valid/ready handshake.
- On command, sweeps every RAM address with a fill value.
- Sits directly in front of the RAM write port; read ports are not touched.

Parameters:
- NREQ, 4, number of write requesters (2..8)
- AW, 6, RAM address width (depth = 2**AW)
- DW, 16, RAM data width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- init_start  input  1  single-cycle pulse; start the fill sweep
- init_data  input  DW  fill value; sampled when init_start is accepted
- init_busy  output  1  high while the sweep is running
- init_done  output  1  one-cycle pulse after the last fill write
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*AW  per-requester address; requester i uses bits [i*AW +: AW]
- req_data  input  NREQ*DW  per-requester data; requester i uses bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high
- grant_id  output  clog2(NREQ)  index of the granted requester; valid only while ram_we is high
- ram_we  output  1  RAM write enable (registered)
- ram_wa  output  AW  RAM write address (registered)
- ram_di  output  DW  RAM write data (registered)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, fill counter=0, ram_we=0, ram_wa=0, ram_di=0, grant_id=0, init_busy=0, init_done=0, req_ready=0. Takes effect immediately, including mid-sweep or mid-transfer; an in-flight write is dropped.
- FSM states: IDLE, INIT.
- IDLE, arbitration:
  - req_ready is combinational from req_valid and rr_ptr.
  - Search starts at index rr_ptr and wraps upward modulo NREQ; the first asserted req_valid wins.
  - At most one req_ready bit is high, and only for a requester whose req_valid is high.
  - On a transfer from requester i: ram_we<=1, ram_wa<=addr_i, ram_di<=data_i, grant_id<=i, rr_ptr<=(i+1) mod NREQ.
  - With no request: ram_we<=0 and rr_ptr holds.
- Throughput: one write per cycle, no bubbles between back-to-back grants.
- Latency: handshake in cycle N -> ram_we high in cycle N+1 -> RAM location written at the rising edge ending cycle N+1. Readback via the async read port is valid from cycle N+2.
- Requesters must hold addr/data stable while valid is high and not yet granted. A requester may drop valid at any time before it is granted.
- init_start in IDLE:
  - Has priority over requests: req_ready is 0 in that cycle and no grant occurs.
  - Latch init_data, set counter=0, init_busy<=1, go to INIT.
- INIT:
  - Each cycle: ram_we<=1, ram_wa<=counter, ram_di<=latched fill value, counter<=counter+1.
  - req_ready is forced to 0; init_start is ignored.
  - After issuing address 2**AW-1 (the counter wraps to 0): return to IDLE, init_busy<=0, init_done<=1 for exactly one cycle. init_done coincides with the cycle in which ram_we carries the last fill write.
- Sweep timing: exactly 2**AW consecutive write cycles (64 at defaults), addresses strictly ascending 0..63, no gaps.
- grant_id during fill writes is don't-care.
- Arbitration resumes in the cycle after init_busy falls, using the rr_ptr value held from before the sweep.
- Simultaneous events:
  - init_start wins over any req_valid.
  - Two writes to the same address in consecutive cycles: the later one persists in the RAM.

Test Plan:
- Reset then single request: req_valid=4'b0100, addr=5, data=16'hBEEF. Required: req_ready=4'b0100 in the same cycle; next cycle ram_we=1, ram_wa=5, ram_di=BEEF, grant_id=2; read port returns BEEF at address 5 two cycles after the handshake.
- Fairness: all four requesters hold valid continuously for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3, one grant per cycle, never two bits of req_ready high.
- Pointer wrap and skip: first grant requester 3, then only requesters 1 and 3 valid. Required: requester 1 is granted next (rr_ptr wraps past 0), then requester 3.
- Init sweep: init_start with init_data=16'h00A5 while requester 0 is valid. Required: req_ready=0 for 65 cycles (the init_start cycle plus 64 sweep cycles); ram_wa steps 0..63; init_done pulses once at ram_wa=63; afterwards both read ports return 00A5 at every address; the pending requester 0 is granted in the cycle after init_busy falls.
- Reset mid-sweep: assert rst_n=0 at fill address 20. Required: ram_we, init_busy and init_done go to 0 immediately without a clock edge; after release the block is in IDLE and a new init_start restarts the sweep at address 0.
- init_start during INIT: pulse it again at fill address 30. Required: ignored; the sweep still ends at address 63 with a single init_done pulse.
